fp32_sub_seq: RTL and testbench
===============================

FP32_SUB_SEQ -- requirements
Module: fp32_sub_seq

Interface
REQ-001 The block SHALL have parameter NORM_BITS_PER_CYCLE, default 1, giving left-normalisation shift per NORM cycle; legal values are 1, 2, 4 and 8.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; reset is synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1, operand pair present.
REQ-005 The block SHALL have port in_ready, output, 1, block can accept operands.
REQ-006 The block SHALL have port operand_1, input, 32, IEEE-754 binary32 minuend.
REQ-007 The block SHALL have port operand_2, input, 32, IEEE-754 binary32 subtrahend.
REQ-008 The block SHALL have port out_valid, output, 1, difference available.
REQ-009 The block SHALL have port out_ready, input, 1, consumer accepts the difference.
REQ-010 The block SHALL have port sub_output, output, 32, binary32 result of operand_1 - operand_2.
REQ-011 The block SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-012 The block SHALL accept operands on a rising edge where in_valid && in_ready, and register both operands.
REQ-013 in_ready SHALL be high only in IDLE; in_valid outside IDLE SHALL be ignored.
REQ-014 The FSM SHALL use states IDLE -> UNPACK -> ALIGN -> ADD -> NORM -> ROUND -> DONE -> IDLE.
REQ-015 UNPACK SHALL form sign/exponent/24-bit significand with the hidden bit set for nonzero exponent, invert operand_2 sign, and detect specials.
REQ-016 ALIGN SHALL right-shift the smaller-exponent significand in one cycle, keeping guard, round and an OR-reduced sticky bit; shifts >= 27 SHALL yield zero significand with sticky = any bit shifted out.
REQ-017 ADD SHALL add magnitudes on equal effective signs, else subtract smaller from larger with the larger operand's sign; a carry-out SHALL right-shift 1 and increment exponent in the same cycle.
REQ-018 NORM SHALL left-shift by up to NORM_BITS_PER_CYCLE per cycle, decrementing exponent, until bit 23 is set, the significand is zero, or exponent reaches 1.
REQ-019 ROUND SHALL apply round-to-nearest-even using LSB, guard, round and sticky; a rounding carry SHALL renormalise and increment exponent.
REQ-020 Latency SHALL be 5 + ceil(k / NORM_BITS_PER_CYCLE) cycles from accept edge to out_valid, where k is the normalisation shift count (k = 0 gives 5).
REQ-021 In DONE, out_valid SHALL be high and sub_output stable until out_ready; the accepting edge SHALL return to IDLE.
REQ-022 Any NaN input, or inf - inf of equal signs, SHALL give 32'h7FC00000; inf otherwise passes with its effective sign; specials SHALL skip ALIGN..ROUND and go UNPACK -> DONE.
REQ-023 Exponent reaching 255 after rounding SHALL give signed infinity.
REQ-024 An exact-zero difference SHALL give +0, except (-0) - (+0) SHALL give -0.

Reset
REQ-025 With rst high on a rising edge, state SHALL be IDLE; out_valid=0, busy=0, sub_output=0, in_ready=1 on the next cycle.
REQ-026 rst asserted in any state, including mid-NORM, SHALL discard the operation with no out_valid pulse.

Configuration
REQ-027 Macro FP32_SUB_SUBNORM_EN defined: subnormal inputs use exponent 1 with hidden bit 0, and results below the normal range are emitted as subnormals.
REQ-028 FP32_SUB_SUBNORM_EN undefined: inputs with exponent 0 are treated as signed zero, and results below the normal range are flushed to signed zero.

Structure
REQ-029 Package fp32_pkg SHALL hold field widths, EXP_BIAS=127, FP32_QNAN, FP32_POS_INF and the FSM state typedef.
REQ-030 Sub-module fp32_unpack (combinational field split, class detect: zero/subnormal/normal/inf/NaN) SHALL be instantiated twice.

Verification
REQ-031 3F800000 - 3F800000 -> sub_output 00000000, out_valid 5 cycles after accept.
REQ-032 40400000 - 3F800000 -> 40000000; 7F7FFFFF - FF7FFFFF -> 7F800000.
REQ-033 3F800000 - 3F800001 -> B4000000 after 23 NORM steps (latency 28 with NORM_BITS_PER_CYCLE=1, 8 with 8).
REQ-034 7F800000 - 7F800000 -> 7FC00000 at latency 2; FF800000 - 7F800000 -> FF800000.
REQ-035 out_ready low 10 cycles in DONE -> sub_output and out_valid held constant; in_valid pulses during that time ignored.
REQ-036 rst pulse during NORM -> no out_valid, in_ready=1 next cycle, next operands processed correctly.

Source files
------------

// File: rtl/fp32_pkg.sv
// rtl/fp32_pkg.sv - shared field widths, constants, FSM states and helpers for the binary32 subtractor
package fp32_pkg;

  localparam int EXP_W    = 8;
  localparam int FRAC_W   = 23;
  localparam int SIG_W    = FRAC_W + 1;
  localparam int EXP_BIAS = 127;

  // Biased exponent value reserved for inf/NaN.
  localparam logic [EXP_W:0] EXP_MAX = 9'(2 * EXP_BIAS + 1);

  localparam logic [31:0] FP32_QNAN    = 32'h7FC00000;
  localparam logic [31:0] FP32_POS_INF = 32'h7F800000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UNPACK,
    ST_ALIGN,
    ST_ADD,
    ST_NORM,
    ST_ROUND,
    ST_DONE
  } state_t;

  typedef enum logic [2:0] {
    FP_ZERO,
    FP_SUBNORM,
    FP_NORMAL,
    FP_INF,
    FP_NAN
  } fp_class_t;

  // Exponent carries one spare bit so the carry out of ADD/ROUND is visible.
  typedef struct packed {
    logic             sign;
    logic [EXP_W:0]   exp;
    logic [SIG_W-1:0] sig;
    fp_class_t        cls;
  } fp_unpacked_t;

  // Working significand is {24-bit significand, guard, round, sticky}.
  function automatic logic norm_needed(input logic [SIG_W+2:0] mant, input logic [EXP_W:0] exp);
    return !mant[SIG_W+2] && (mant != '0) && (exp > 9'd1);
  endfunction

endpackage

// File: rtl/fp32_unpack.sv
// rtl/fp32_unpack.sv - combinational binary32 field split and class detect; FP32_SUB_SUBNORM_EN keeps subnormals
module fp32_unpack
  import fp32_pkg::*;
(
  input  logic [31:0]  value,
  input  logic         flip_sign,
  output fp_unpacked_t fields
);

  logic [EXP_W-1:0]  exp_raw;
  logic [FRAC_W-1:0] frac;

  assign exp_raw = value[30:23];
  assign frac    = value[22:0];

  // Split fields, restore the hidden bit and classify the operand.
  always_comb begin
    fields.sign = value[31] ^ flip_sign;
    fields.exp  = {1'b0, exp_raw};
    fields.sig  = {1'b1, frac};
    fields.cls  = FP_NORMAL;
    if (exp_raw == '1) begin
      fields.cls = (frac == '0) ? FP_INF : FP_NAN;
    end else if (exp_raw == '0) begin
      // Exponent-zero encodings sit at exponent 1 so alignment distances stay correct.
      fields.exp = 9'd1;
`ifdef FP32_SUB_SUBNORM_EN
      fields.sig = {1'b0, frac};
`else
      fields.sig = '0;
`endif
      fields.cls = (frac == '0) ? FP_ZERO : FP_SUBNORM;
    end
  end

endmodule

// File: rtl/fp32_sub_seq.sv
// rtl/fp32_sub_seq.sv - multi-cycle binary32 subtractor (operand_1 - operand_2); FP32_SUB_SUBNORM_EN enables subnormals
module fp32_sub_seq
  import fp32_pkg::*;
#(
  parameter int NORM_BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] operand_1,
  input  logic [31:0] operand_2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] sub_output,
  output logic        busy
);

  localparam int MANT_W = SIG_W + 3;

  state_t state;

  logic [31:0]       op_a;
  logic [31:0]       op_b;
  logic              sign_a;
  logic              sign_b;
  logic [EXP_W:0]    exp_a;
  logic [EXP_W:0]    exp_b;
  logic [SIG_W-1:0]  sig_a;
  logic [SIG_W-1:0]  sig_b;
  logic [MANT_W-1:0] big_mant;
  logic [MANT_W-1:0] small_mant;
  logic [MANT_W-1:0] work_mant;
  logic [EXP_W:0]    res_exp;
  logic              res_sign;

  fp_unpacked_t ua;
  fp_unpacked_t ub;

  fp32_unpack u_unpack_a (
    .value     (op_a),
    .flip_sign (1'b0),
    .fields    (ua)
  );

  // The subtrahend's sign is inverted so the rest of the datapath is an adder.
  fp32_unpack u_unpack_b (
    .value     (op_b),
    .flip_sign (1'b1),
    .fields    (ub)
  );

  logic        special;
  logic [31:0] special_res;

  // Detect NaN/inf operands and pick the result that bypasses the arithmetic path.
  always_comb begin
    special     = 1'b0;
    special_res = FP32_QNAN;
    if (ua.cls == FP_NAN || ub.cls == FP_NAN) begin
      special     = 1'b1;
      special_res = FP32_QNAN;
    end else if (ua.cls == FP_INF && ub.cls == FP_INF) begin
      special     = 1'b1;
      special_res = (ua.sign == ub.sign) ? {ua.sign, FP32_POS_INF[30:0]} : FP32_QNAN;
    end else if (ua.cls == FP_INF) begin
      special     = 1'b1;
      special_res = {ua.sign, FP32_POS_INF[30:0]};
    end else if (ub.cls == FP_INF) begin
      special     = 1'b1;
      special_res = {ub.sign, FP32_POS_INF[30:0]};
    end
  end

  logic              a_bigger;
  logic              big_sign;
  logic [EXP_W:0]    big_exp;
  logic [EXP_W:0]    small_exp;
  logic [SIG_W-1:0]  big_sig;
  logic [SIG_W-1:0]  small_sig;
  logic [EXP_W:0]    shift_amt;
  logic [5:0]        shift_cl;
  logic [2*MANT_W-1:0] shift_tmp;
  logic [MANT_W-1:0] aligned_small;

  // Order operands by magnitude and right-shift the smaller one, folding lost bits into sticky.
  always_comb begin
    a_bigger  = {exp_a, sig_a} >= {exp_b, sig_b};
    big_sign  = a_bigger ? sign_a : sign_b;
    big_exp   = a_bigger ? exp_a : exp_b;
    small_exp = a_bigger ? exp_b : exp_a;
    big_sig   = a_bigger ? sig_a : sig_b;
    small_sig = a_bigger ? sig_b : sig_a;
    shift_amt = big_exp - small_exp;
    shift_cl  = (shift_amt > 9'd27) ? 6'd27 : shift_amt[5:0];
    // Lower half of the double-width shift collects every bit pushed out of the window.
    shift_tmp = {small_sig, 30'd0} >> shift_cl;
    aligned_small = {shift_tmp[2*MANT_W-1:MANT_W+1], shift_tmp[MANT_W] | (|shift_tmp[MANT_W-1:0])};
  end

  logic [MANT_W:0]   sum;
  logic [MANT_W-1:0] add_mant;
  logic [EXP_W:0]    add_exp;

  // Magnitude add or subtract; a carry out is absorbed by a 1-bit right shift.
  always_comb begin
    if (sign_a ^ sign_b) begin
      sum = {1'b0, big_mant} - {1'b0, small_mant};
    end else begin
      sum = {1'b0, big_mant} + {1'b0, small_mant};
    end
    add_mant = sum[MANT_W-1:0];
    add_exp  = res_exp;
    if (sum[MANT_W]) begin
      add_mant = {sum[MANT_W:2], sum[1] | sum[0]};
      add_exp  = res_exp + 9'd1;
    end
  end

  logic [MANT_W-1:0] norm_mant;
  logic [EXP_W:0]    norm_exp;
  logic              norm_done;

  // One NORM cycle: up to NORM_BITS_PER_CYCLE single-bit left shifts, stopping at the first done condition.
  always_comb begin
    norm_mant = work_mant;
    norm_exp  = res_exp;
    for (int i = 0; i < NORM_BITS_PER_CYCLE; i++) begin
      if (norm_needed(norm_mant, norm_exp)) begin
        norm_mant = norm_mant << 1;
        norm_exp  = norm_exp - 9'd1;
      end
    end
    norm_done = !norm_needed(norm_mant, norm_exp);
  end

  logic              round_up;
  logic [SIG_W:0]    sig_rnd;
  logic [SIG_W-1:0]  rnd_sig;
  logic [EXP_W:0]    rnd_exp;
  logic [31:0]       rnd_res;

  // Round to nearest even, renormalise a rounding carry, then pack with overflow/underflow handling.
  always_comb begin
    round_up = work_mant[2] & (work_mant[1] | work_mant[0] | work_mant[3]);
    sig_rnd  = {1'b0, work_mant[MANT_W-1:3]} + {{SIG_W{1'b0}}, round_up};
    rnd_sig  = sig_rnd[SIG_W-1:0];
    rnd_exp  = res_exp;
    if (sig_rnd[SIG_W]) begin
      rnd_sig = sig_rnd[SIG_W:1];
      rnd_exp = res_exp + 9'd1;
    end
    if (rnd_sig == '0) begin
      rnd_res = {res_sign, 31'd0};
    end else if (rnd_exp >= EXP_MAX) begin
      rnd_res = {res_sign, FP32_POS_INF[30:0]};
    end else if (!rnd_sig[SIG_W-1]) begin
      // Hidden bit still clear means normalisation stopped at exponent 1: below the normal range.
`ifdef FP32_SUB_SUBNORM_EN
      rnd_res = {res_sign, 8'd0, rnd_sig[FRAC_W-1:0]};
`else
      rnd_res = {res_sign, 31'd0};
`endif
    end else begin
      rnd_res = {res_sign, rnd_exp[EXP_W-1:0], rnd_sig[FRAC_W-1:0]};
    end
  end

  // Control FSM with registered handshake outputs; datapath registers load in their own state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      in_ready   <= 1'b1;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      sub_output <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            op_a     <= operand_1;
            op_b     <= operand_2;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= ST_UNPACK;
          end
        end
        ST_UNPACK: begin
          sign_a <= ua.sign;
          sign_b <= ub.sign;
          exp_a  <= ua.exp;
          exp_b  <= ub.exp;
          sig_a  <= ua.sig;
          sig_b  <= ub.sig;
          if (special) begin
            sub_output <= special_res;
            out_valid  <= 1'b1;
            state      <= ST_DONE;
          end else begin
            state <= ST_ALIGN;
          end
        end
        ST_ALIGN: begin
          big_mant   <= {big_sig, 3'b000};
          small_mant <= aligned_small;
          res_exp    <= big_exp;
          res_sign   <= big_sign;
          state      <= ST_ADD;
        end
        ST_ADD: begin
          work_mant <= add_mant;
          res_exp   <= add_exp;
          // Exact zero is +0 unless both inputs were zeros of the same effective sign.
          if (add_mant == '0) begin
            res_sign <= sign_a & sign_b;
          end
          state <= norm_needed(add_mant, add_exp) ? ST_NORM : ST_ROUND;
        end
        ST_NORM: begin
          work_mant <= norm_mant;
          res_exp   <= norm_exp;
          if (norm_done) begin
            state <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          sub_output <= rnd_res;
          out_valid  <= 1'b1;
          state      <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_sub_seq.sv
// tb/tb_fp32_sub_seq.sv - directed self-checking bench for fp32_sub_seq
module tb_fp32_sub_seq;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] want;
    logic [7:0]  lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] operand_1;
  logic [31:0] operand_2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sub_output;
  logic        busy;

  logic        in_valid8;
  logic        in_ready8;
  logic        out_valid8;
  logic        out_ready8;
  logic [31:0] sub_output8;
  logic        busy8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fp32_sub_seq #(.NORM_BITS_PER_CYCLE(1)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .operand_1  (operand_1),
    .operand_2  (operand_2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sub_output (sub_output),
    .busy       (busy)
  );

  fp32_sub_seq #(.NORM_BITS_PER_CYCLE(8)) u_dut8 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid8),
    .in_ready   (in_ready8),
    .operand_1  (operand_1),
    .operand_2  (operand_2),
    .out_valid  (out_valid8),
    .out_ready  (out_ready8),
    .sub_output (sub_output8),
    .busy       (busy8)
  );

  // Latency counts the accept edge as cycle 1; lat = 0 means no result within the budget.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    res = '0;
    lat = 0;
    for (int i = 0; i < 50; i++) begin
      if (in_ready) break;
      @(posedge clk); #1;
    end
    operand_1 = a;
    operand_2 = b;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    for (int c = 2; c <= 100; c++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = c;
        res = sub_output;
        break;
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (sub_output !== 32'h0) begin n_fail++; $display("FAIL reset_sub_output got %h want 00000000", sub_output); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_checks++; if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin n_fail++; $display("FAIL reset_dut8 got ready=%b valid=%b want 1/0", in_ready8, out_valid8); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_arith();
    vec_t tbl [0:9];
    logic [31:0] res;
    int lat;
    tbl = '{
      {32'h3F800000, 32'h3F800000, 32'h00000000, 8'd5},
      {32'h40400000, 32'h3F800000, 32'h40000000, 8'd5},
      {32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 8'd5},
      {32'h3F800000, 32'h33800000, 32'h3F7FFFFF, 8'd6},
      {32'h3F800000, 32'hB3800000, 32'h3F800000, 8'd5},
      {32'h3F800001, 32'hB3800000, 32'h3F800002, 8'd5},
      {32'h3FFFFFFF, 32'hB3800000, 32'h40000000, 8'd5},
      {32'h80000000, 32'h00000000, 32'h80000000, 8'd5},
      {32'h00000000, 32'h00000000, 32'h00000000, 8'd5},
      {32'hC0000000, 32'h40000000, 32'hC0800000, 8'd5}
    };
    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].a, tbl[i].b, res, lat);
      n_checks++; if (res !== tbl[i].want) begin n_fail++; $display("FAIL arith[%0d] %h-%h result got %h want %h", i, tbl[i].a, tbl[i].b, res, tbl[i].want); end
      n_checks++; if (lat !== int'(tbl[i].lat)) begin n_fail++; $display("FAIL arith[%0d] latency got %0d want %0d", i, lat, tbl[i].lat); end
    end
  endtask

  task automatic test_specials();
    vec_t tbl [0:4];
    logic [31:0] res;
    int lat;
    tbl = '{
      {32'h7F800000, 32'h7F800000, 32'h7FC00000, 8'd2},
      {32'hFF800000, 32'h7F800000, 32'hFF800000, 8'd2},
      {32'h7FC00001, 32'h3F800000, 32'h7FC00000, 8'd2},
      {32'h3F800000, 32'h7F800000, 32'hFF800000, 8'd2},
      {32'hFF800000, 32'hFF800000, 32'h7FC00000, 8'd2}
    };
    for (int i = 0; i < 5; i++) begin
      run_op(tbl[i].a, tbl[i].b, res, lat);
      n_checks++; if (res !== tbl[i].want) begin n_fail++; $display("FAIL special[%0d] %h-%h result got %h want %h", i, tbl[i].a, tbl[i].b, res, tbl[i].want); end
      n_checks++; if (lat !== int'(tbl[i].lat)) begin n_fail++; $display("FAIL special[%0d] latency got %0d want %0d", i, lat, tbl[i].lat); end
    end
  endtask

  task automatic test_flush();
    vec_t tbl [0:2];
    logic [31:0] res;
    int lat;
    tbl = '{
      {32'h00800001, 32'h00800000, 32'h00000000, 8'd5},
      {32'h00800000, 32'h00000001, 32'h00800000, 8'd5},
      {32'h80800001, 32'h80800000, 32'h80000000, 8'd5}
    };
    for (int i = 0; i < 3; i++) begin
      run_op(tbl[i].a, tbl[i].b, res, lat);
      n_checks++; if (res !== tbl[i].want) begin n_fail++; $display("FAIL flush[%0d] %h-%h result got %h want %h", i, tbl[i].a, tbl[i].b, res, tbl[i].want); end
      n_checks++; if (lat !== int'(tbl[i].lat)) begin n_fail++; $display("FAIL flush[%0d] latency got %0d want %0d", i, lat, tbl[i].lat); end
    end
  endtask

  task automatic test_norm_long();
    logic [31:0] res;
    int lat;
    run_op(32'h3F800000, 32'h3F800001, res, lat);
    n_checks++; if (res !== 32'hB4000000) begin n_fail++; $display("FAIL norm_long result got %h want B4000000", res); end
    n_checks++; if (lat !== 28) begin n_fail++; $display("FAIL norm_long latency got %0d want 28", lat); end
  endtask

  task automatic test_norm_wide();
    vec_t tbl [0:1];
    logic [31:0] res;
    int lat;
    tbl = '{
      {32'h3F800000, 32'h3F800001, 32'hB4000000, 8'd8},
      {32'h3F800000, 32'h33800000, 32'h3F7FFFFF, 8'd6}
    };
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (in_ready8 !== 1'b1) begin n_fail++; $display("FAIL wide[%0d] in_ready got %b want 1", i, in_ready8); end
      operand_1 = tbl[i].a;
      operand_2 = tbl[i].b;
      in_valid8 = 1'b1;
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      res = '0;
      lat = 0;
      for (int c = 2; c <= 100; c++) begin
        @(posedge clk); #1;
        if (out_valid8) begin
          lat = c;
          res = sub_output8;
          break;
        end
      end
      out_ready8 = 1'b1;
      @(posedge clk); #1;
      out_ready8 = 1'b0;
      n_checks++; if (res !== tbl[i].want) begin n_fail++; $display("FAIL wide[%0d] result got %h want %h", i, res, tbl[i].want); end
      n_checks++; if (lat !== int'(tbl[i].lat)) begin n_fail++; $display("FAIL wide[%0d] latency got %0d want %0d", i, lat, tbl[i].lat); end
    end
  endtask

  task automatic test_hold();
    logic [31:0] res;
    int lat;
    operand_1 = 32'h40A00000;
    operand_2 = 32'h3F800000;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    lat = 0;
    for (int c = 2; c <= 100; c++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = c;
        break;
      end
    end
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL hold_latency got %0d want 5", lat); end
    for (int i = 0; i < 10; i++) begin
      operand_1 = 32'h41200000;
      operand_2 = 32'h3F800000;
      in_valid  = (i % 2 == 0);
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b1 || sub_output !== 32'h40800000) begin n_fail++; $display("FAIL hold[%0d] got valid=%b data=%h want 1/40800000", i, out_valid, sub_output); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_ready[%0d] got %b want 0", i, in_ready); end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL hold_release got valid=%b ready=%b busy=%b want 0/1/0", out_valid, in_ready, busy); end
    run_op(32'h3F800000, 32'h40000000, res, lat);
    n_checks++; if (res !== 32'hBF800000) begin n_fail++; $display("FAIL hold_next result got %h want BF800000", res); end
    n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL hold_next latency got %0d want 6", lat); end
  endtask

  task automatic test_reset_mid_norm();
    logic [31:0] res;
    int lat;
    int seen;
    operand_1 = 32'h3F800000;
    operand_2 = 32'h3F800001;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL midnorm_busy got busy=%b valid=%b want 1/0", busy, out_valid); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL midnorm_reset got ready=%b busy=%b valid=%b want 1/0/0", in_ready, busy, out_valid); end
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL midnorm_no_pulse got %0d valid cycles want 0", seen); end
    run_op(32'h40400000, 32'h3F800000, res, lat);
    n_checks++; if (res !== 32'h40000000) begin n_fail++; $display("FAIL midnorm_next result got %h want 40000000", res); end
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL midnorm_next latency got %0d want 5", lat); end
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    in_valid8  = 1'b0;
    out_ready8 = 1'b0;
    operand_1  = '0;
    operand_2  = '0;
    test_reset();
    test_arith();
    test_specials();
    test_flush();
    test_norm_long();
    test_norm_wide();
    test_hold();
    test_reset_mid_norm();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
